printf_uart_rx_fifo: RTL and testbench
======================================

# printf_uart_rx_fifo

Serial-to-byte receiver for the `printf_tx` line driven by the platform FPGA top. It oversamples the 8N1 UART stream and rejects start-bit glitches. Completed bytes go into a small FIFO, which presents them on a valid/ready byte interface to an on-board consumer such as a log capture buffer or a debug bridge. Framing errors and overflows are reported as single-cycle pulses and are also counted.

## Interface
- `BAUD_DIV`, 16: clock cycles per bit; even value, at least 4.
- `FIFO_DEPTH`, 8: byte FIFO entries; power of two, at least 2.
- `CNT_W`, 8: width of the error counters.
- `clk` input 1: single clock for the whole block.
- `rst` input 1: asynchronous, active-high reset.
- `rx_serial` input 1: UART line, idle high; connects to the platform `printf_tx`.
- `rxd_valid` output 1: the FIFO head byte is available.
- `rxd_ready` input 1: consumer accepts the head byte.
- `rxd_data` output 8: FIFO head byte.
- `fifo_level` output $clog2(FIFO_DEPTH)+1: current occupancy.
- `frame_err` output 1: one-cycle pulse when the stop bit samples low.
- `overflow` output 1: one-cycle pulse when a completed byte is dropped because the FIFO is full.
- `frame_err_cnt` output CNT_W: saturating count of framing errors.
- `overflow_cnt` output CNT_W: saturating count of dropped bytes.

## Operation
- Input conditioning: `rx_serial` passes through a 2-flop synchronizer. On reset both flops load 1. Call the synchronizer output `rxs`.
- The receiver FSM has states IDLE, START, DATA, STOP and WAIT_IDLE, plus a bit counter `bcnt` (0..7) and a baud counter `dcnt`.
- IDLE: when `rxs`=0, go to START and load `dcnt`=BAUD_DIV/2-1.
- START: decrement `dcnt`. At 0, sample `rxs`.
  - If 1, treat it as a glitch and return to IDLE with no flag.
  - If 0, go to DATA with `dcnt`=BAUD_DIV-1 and `bcnt`=0.
- DATA: at `dcnt`=0, shift `rxs` into the shift register (LSB first) and reload `dcnt`. After the sample with `bcnt`=7, go to STOP; otherwise increment `bcnt`.
- STOP: at `dcnt`=0, sample `rxs`.
  - If 1, push the byte and return to IDLE.
  - If 0, pulse `frame_err`, discard the byte and go to WAIT_IDLE.
- WAIT_IDLE: remain until `rxs`=1, then go to IDLE. This keeps a break condition from producing repeated bytes or errors.
- FIFO push:
  - The push is accepted iff occupancy before this cycle's pop is below FIFO_DEPTH.
  - Otherwise the byte is dropped and `overflow` pulses.
  - A push and a pop in the same cycle when the FIFO is full still drops the byte. This is a deliberate, deterministic rule.
- FIFO pop: occurs when `rxd_valid && rxd_ready`. `rxd_data` is valid whenever `rxd_valid`=1 and holds stable until popped.
- Counters: `frame_err_cnt` increments on each `frame_err` pulse and `overflow_cnt` on each `overflow` pulse. Both saturate at 2^CNT_W-1.
- Pointers: FIFO pointers wrap modulo FIFO_DEPTH. `fifo_level` is the registered occupancy.

## Timing
- Reset values:
  - FSM in IDLE.
  - `rxd_valid`=0, `rxd_data`=0, `fifo_level`=0.
  - `frame_err`=0, `overflow`=0.
  - Both counters 0.
  - Synchronizer flops at 1.
- Reset asserted mid-frame: the partial byte and all FIFO contents are lost, and the FSM is in IDLE on the first clock after deassertion.
- Input latency: `rxs` follows `rx_serial` by 2 cycles.
- Let t0 be the cycle IDLE sees `rxs`=0. The stop sample occurs at t0 + BAUD_DIV/2 + 9·BAUD_DIV.
- At the stop sample cycle +1, one of the following is true:
  - `rxd_valid` is high (if the FIFO was empty) and `fifo_level` is updated.
  - `frame_err` is high.
  - `overflow` is high.
- Pop: `fifo_level` decrements and the next head byte appears on the cycle after the `valid && ready` edge.
- Back-to-back frames: a start bit immediately following a good stop sample is detected without a lost cycle.

## Structure
- Shared package `printf_uart_rx_pkg` holds:
  - the state encoding `rx_state_t` (IDLE=0, START, DATA, STOP, WAIT_IDLE);
  - `UART_DATA_BITS`=8.
- One sub-module, `printf_rx_byte_fifo`. It is a synchronous FIFO parameterized by width and depth, with `push`, `full`, `pop`, `empty` and `level`.
- The synchronizer, FSM and counters live in the top module.

## Test plan
All scenarios use BAUD_DIV=16.
- Byte 0x55 sent at exact baud, consumer ready -> `rxd_data`=0x55 and `rxd_valid` high at t0+152; no flags.
- A 5-cycle low glitch on an idle line -> no byte, no `frame_err`, FSM back in IDLE.
- 0xA3 sent with the stop bit held low for 3 bit times -> one `frame_err` pulse, `frame_err_cnt`=1, no byte. A following 0x41 is received correctly.
- FIFO_DEPTH=8, `rxd_ready`=0, 10 bytes 0x00..0x09 sent -> `fifo_level`=8, two `overflow` pulses, `overflow_cnt`=2. Popping then yields 0x00..0x07 in order.
- Reset asserted during bit 4 of a frame -> all outputs at reset values. The next full frame 0x7E is received correctly.
- FIFO full with `rxd_ready`=1 in the same cycle a new byte completes -> one byte popped, the new byte dropped, `overflow` pulses, `fifo_level`=7.

Source files
------------

// File: rtl/printf_uart_rx_fifo_pkg.sv
// Shared types for the printf UART receiver:
// receiver state encoding and frame width.
package printf_uart_rx_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } rx_state_t;

endpackage

// File: rtl/printf_uart_rx_fifo_if.sv
// Valid/ready byte stream from the receiver FIFO
// to its consumer.
interface printf_uart_rx_fifo_if
  import printf_uart_rx_pkg::*;
#(
  parameter int W = UART_DATA_BITS
);

  logic         rxd_valid;
  logic         rxd_ready;
  logic [W-1:0] rxd_data;

  modport master (
    output rxd_valid,
    output rxd_data,
    input  rxd_ready
  );

  modport slave (
    input  rxd_valid,
    input  rxd_data,
    output rxd_ready
  );

endinterface

// File: rtl/printf_uart_rx_fifo_fifo.sv
// Synchronous FIFO with registered occupancy.
// A push is judged against the level before any same-cycle pop.
module printf_rx_byte_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic [W-1:0]           data_i,
  output logic                   full_o,
  input  logic                   pop_i,
  output logic [W-1:0]           data_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] level_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q;
  logic [AW-1:0] rptr_q;
  logic [AW:0]   level_q;
  logic [AW:0]   level_d;
  logic          wr_en;
  logic          rd_en;

  // Level never exceeds DEPTH, a power of two,
  // so its MSB alone marks the full condition.
  assign full_o  = level_q[AW];
  assign empty_o = (level_q == '0);
  assign wr_en   = push_i & ~full_o;
  assign rd_en   = pop_i & ~empty_o;
  assign data_o  = mem_q[rptr_q];
  assign level_o = level_q;

  always_comb begin
    level_d = level_q;
    if (wr_en && !rd_en) begin
      level_d = level_q + 1'b1;
    end else if (rd_en && !wr_en) begin
      level_d = level_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (wr_en) begin
        mem_q[wptr_q] <= data_i;
        wptr_q        <= wptr_q + 1'b1;
      end
      if (rd_en) begin
        rptr_q <= rptr_q + 1'b1;
      end
      level_q <= level_d;
    end
  end

endmodule

// File: rtl/printf_uart_rx_fifo.sv
// 8N1 receiver for the printf_tx line: synchronizer,
// receive FSM, byte FIFO and saturating error counters.
module printf_uart_rx_fifo
  import printf_uart_rx_pkg::*;
#(
  parameter int BAUD_DIV   = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        rx_serial,
  printf_uart_rx_fifo_if.master       rxd,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        frame_err,
  output logic                        overflow,
  output logic [CNT_W-1:0]            frame_err_cnt,
  output logic [CNT_W-1:0]            overflow_cnt
);

  localparam int DW = $clog2(BAUD_DIV);
  localparam int BW = $clog2(UART_DATA_BITS);

  localparam logic [DW-1:0] HALF_BIT =
    DW'(BAUD_DIV / 2 - 1);
  localparam logic [DW-1:0] FULL_BIT =
    DW'(BAUD_DIV - 1);
  localparam logic [BW-1:0] LAST_BIT =
    BW'(UART_DATA_BITS - 1);

  logic                      sync1_q;
  logic                      sync2_q;
  logic                      rxs;
  rx_state_t                 state_q;
  logic [DW-1:0]             dcnt_q;
  logic [BW-1:0]             bcnt_q;
  logic [UART_DATA_BITS-1:0] shreg_q;
  logic                      frame_err_q;
  logic                      overflow_q;
  logic [CNT_W-1:0]          fe_cnt_q;
  logic [CNT_W-1:0]          ov_cnt_q;

  logic push;
  logic pop;
  logic full;
  logic empty;
  logic stop_tick;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= rx_serial;
      sync2_q <= sync1_q;
    end
  end

  assign rxs = sync2_q;

  // The FIFO write lands on the same edge as the stop sample
  // so the byte is visible one cycle after it.
  assign stop_tick = (state_q == STOP) && (dcnt_q == '0);
  assign push      = stop_tick && rxs;
  assign pop       = rxd.rxd_valid && rxd.rxd_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      dcnt_q      <= '0;
      bcnt_q      <= '0;
      shreg_q     <= '0;
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (!rxs) begin
            state_q <= START;
            dcnt_q  <= HALF_BIT;
          end
        end
        START: begin
          if (dcnt_q != '0) begin
            dcnt_q <= dcnt_q - 1'b1;
          end else if (rxs) begin
            state_q <= IDLE;
          end else begin
            state_q <= DATA;
            dcnt_q  <= FULL_BIT;
            bcnt_q  <= '0;
          end
        end
        DATA: begin
          if (dcnt_q != '0) begin
            dcnt_q <= dcnt_q - 1'b1;
          end else begin
            shreg_q <= {rxs, shreg_q[UART_DATA_BITS-1:1]};
            dcnt_q  <= FULL_BIT;
            if (bcnt_q == LAST_BIT) begin
              state_q <= STOP;
            end else begin
              bcnt_q <= bcnt_q + 1'b1;
            end
          end
        end
        STOP: begin
          if (dcnt_q != '0) begin
            dcnt_q <= dcnt_q - 1'b1;
          end else if (rxs) begin
            state_q <= IDLE;
          end else begin
            frame_err_q <= 1'b1;
            state_q     <= WAIT_IDLE;
          end
        end
        WAIT_IDLE: begin
          if (rxs) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_q <= 1'b0;
      fe_cnt_q   <= '0;
      ov_cnt_q   <= '0;
    end else begin
      overflow_q <= push && full;
      if (frame_err_q && (fe_cnt_q != '1)) begin
        fe_cnt_q <= fe_cnt_q + 1'b1;
      end
      if (overflow_q && (ov_cnt_q != '1)) begin
        ov_cnt_q <= ov_cnt_q + 1'b1;
      end
    end
  end

  printf_rx_byte_fifo #(
    .W     (UART_DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .data_i  (shreg_q),
    .full_o  (full),
    .pop_i   (pop),
    .data_o  (rxd.rxd_data),
    .empty_o (empty),
    .level_o (fifo_level)
  );

  assign rxd.rxd_valid = ~empty;
  assign frame_err     = frame_err_q;
  assign overflow      = overflow_q;
  assign frame_err_cnt = fe_cnt_q;
  assign overflow_cnt  = ov_cnt_q;

endmodule

// File: tb/tb_printf_uart_rx_fifo.sv
// Bench for printf_uart_rx_fifo: random bytes framed as 8N1
// and compared with a queue model of the receive FIFO.
module tb_printf_uart_rx_fifo;
  import printf_uart_rx_pkg::*;

  localparam int BAUD  = 16;
  localparam int DEPTH = 8;
  localparam int CW    = 8;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rx_serial = 1'b1;
  logic [LW-1:0] fifo_level;
  logic          frame_err;
  logic          overflow;
  logic [CW-1:0] fe_cnt;
  logic [CW-1:0] ov_cnt;

  printf_uart_rx_fifo_if #(.W(8)) rxd ();

  printf_uart_rx_fifo #(
    .BAUD_DIV   (BAUD),
    .FIFO_DEPTH (DEPTH),
    .CNT_W      (CW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .rx_serial     (rx_serial),
    .rxd           (rxd),
    .fifo_level    (fifo_level),
    .frame_err     (frame_err),
    .overflow      (overflow),
    .frame_err_cnt (fe_cnt),
    .overflow_cnt  (ov_cnt)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // model state: bytes accepted, expected pulses
  logic [7:0] acc_q[$];
  int exp_fe = 0;
  int exp_ovf = 0;

  // observed stream and pulses
  logic [7:0] got_q[$];
  int fe_seen = 0;
  int ov_seen = 0;

  always @(posedge clk) begin
    if (rst) begin
      got_q.delete();
      fe_seen = 0;
      ov_seen = 0;
    end else begin
      if (rxd.rxd_valid && rxd.rxd_ready)
        got_q.push_back(rxd.rxd_data);
      if (frame_err) fe_seen++;
      if (overflow) ov_seen++;
    end
  end

  // Drives one frame starting at a negedge. The model decides the
  // frame's fate in the stop-sample cycle, before any pop that edge.
  task automatic send_byte(input logic [7:0] b,
                           input logic stop_ok,
                           input int stop_bits);
    int occ;
    rx_serial = 1'b0;
    repeat (BAUD) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_serial = b[i];
      repeat (BAUD) @(negedge clk);
    end
    rx_serial = stop_ok;
    repeat (BAUD / 2 + 2) @(negedge clk);
    occ = acc_q.size() - got_q.size();
    if (!stop_ok) exp_fe++;
    else if (occ < DEPTH) acc_q.push_back(b);
    else exp_ovf++;
    if (stop_ok) begin
      repeat (BAUD / 2 - 2) @(negedge clk);
    end else begin
      repeat (stop_bits * BAUD - BAUD / 2 - 2) @(negedge clk);
      rx_serial = 1'b1;
      repeat (BAUD) @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rxd.rxd_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (rxd.rxd_valid !== 1'b0 || rxd.rxd_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_out valid=%b data=%h want 0/00",
               rxd.rxd_valid, rxd.rxd_data);
    end
    checks++;
    if (fifo_level !== '0 || frame_err !== 1'b0 ||
        overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags lvl=%0d fe=%b ov=%b want 0",
               fifo_level, frame_err, overflow);
    end
    checks++;
    if (fe_cnt !== '0 || ov_cnt !== '0 ||
        dut.state_q !== IDLE) begin
      errors++;
      $display("FAIL reset_cnt fe=%0d ov=%0d st=%0d want 0",
               fe_cnt, ov_cnt, dut.state_q);
    end
    rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_single();
    rxd.rxd_ready = 1'b1;
    @(negedge clk);
    fork
      send_byte(8'h55, 1'b1, 1);
      begin
        repeat (154) @(posedge clk);
        @(negedge clk);
        checks++;
        if (rxd.rxd_valid !== 1'b0) begin
          errors++;
          $display("FAIL single_early valid=%b want 0",
                   rxd.rxd_valid);
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (rxd.rxd_valid !== 1'b1 || rxd.rxd_data !== 8'h55) begin
          errors++;
          $display("FAIL single_t152 valid=%b data=%h want 1/55",
                   rxd.rxd_valid, rxd.rxd_data);
        end
      end
    join
    repeat (20) @(negedge clk);
    checks++;
    if (got_q.size() != 1 || got_q[0] !== 8'h55) begin
      errors++;
      $display("FAIL single_stream n=%0d want 1 byte 55",
               got_q.size());
    end
    checks++;
    if (fe_seen != 0 || ov_seen != 0) begin
      errors++;
      $display("FAIL single_flags fe=%0d ov=%0d want 0",
               fe_seen, ov_seen);
    end
  endtask

  task automatic test_glitch();
    int n0;
    n0 = got_q.size();
    rx_serial = 1'b0;
    repeat (5) @(negedge clk);
    rx_serial = 1'b1;
    repeat (40) @(negedge clk);
    checks++;
    if (got_q.size() != n0 || rxd.rxd_valid !== 1'b0) begin
      errors++;
      $display("FAIL glitch_byte n=%0d valid=%b want %0d/0",
               got_q.size(), rxd.rxd_valid, n0);
    end
    checks++;
    if (fe_seen != exp_fe || dut.state_q !== IDLE) begin
      errors++;
      $display("FAIL glitch_state fe=%0d st=%0d want %0d/IDLE",
               fe_seen, dut.state_q, exp_fe);
    end
  endtask

  task automatic test_frame_err();
    send_byte(8'hA3, 1'b0, 3);
    send_byte(8'h41, 1'b1, 1);
    repeat (20) @(negedge clk);
    checks++;
    if (fe_seen != exp_fe || fe_cnt !== CW'(exp_fe)) begin
      errors++;
      $display("FAIL ferr_count pulses=%0d cnt=%0d want %0d",
               fe_seen, fe_cnt, exp_fe);
    end
    checks++;
    if (got_q.size() != acc_q.size()) begin
      errors++;
      $display("FAIL ferr_len got=%0d want %0d",
               got_q.size(), acc_q.size());
    end else begin
      for (int i = 0; i < got_q.size(); i++) begin
        checks++;
        if (got_q[i] !== acc_q[i]) begin
          errors++;
          $display("FAIL ferr_data[%0d] got=%h want %h",
                   i, got_q[i], acc_q[i]);
        end
      end
    end
  endtask

  task automatic test_overflow();
    rxd.rxd_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      send_byte(8'(i), 1'b1, 1);
    end
    repeat (20) @(negedge clk);
    checks++;
    if (fifo_level !== LW'(acc_q.size() - got_q.size())) begin
      errors++;
      $display("FAIL ovf_level got=%0d want %0d", fifo_level,
               acc_q.size() - got_q.size());
    end
    checks++;
    if (ov_seen != exp_ovf || ov_cnt !== CW'(exp_ovf)) begin
      errors++;
      $display("FAIL ovf_count pulses=%0d cnt=%0d want %0d",
               ov_seen, ov_cnt, exp_ovf);
    end
    rxd.rxd_ready = 1'b1;
    repeat (12) @(negedge clk);
    rxd.rxd_ready = 1'b0;
    checks++;
    if (got_q.size() != acc_q.size() || fifo_level !== '0) begin
      errors++;
      $display("FAIL ovf_drain got=%0d lvl=%0d want %0d/0",
               got_q.size(), fifo_level, acc_q.size());
    end else begin
      for (int i = 0; i < got_q.size(); i++) begin
        checks++;
        if (got_q[i] !== acc_q[i]) begin
          errors++;
          $display("FAIL ovf_data[%0d] got=%h want %h",
                   i, got_q[i], acc_q[i]);
        end
      end
    end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] p;
    p = 8'h7E;
    rxd.rxd_ready = 1'b0;
    send_byte(8'h33, 1'b1, 1);
    rx_serial = 1'b0;
    repeat (BAUD) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx_serial = p[i];
      repeat (BAUD) @(negedge clk);
    end
    rx_serial = p[4];
    repeat (BAUD / 2) @(negedge clk);
    rst = 1'b1;
    rx_serial = 1'b1;
    acc_q.delete();
    exp_fe = 0;
    exp_ovf = 0;
    repeat (2) @(negedge clk);
    checks++;
    if (rxd.rxd_valid !== 1'b0 || rxd.rxd_data !== 8'h00 ||
        fifo_level !== '0) begin
      errors++;
      $display("FAIL midrst_fifo valid=%b data=%h lvl=%0d want 0",
               rxd.rxd_valid, rxd.rxd_data, fifo_level);
    end
    checks++;
    if (fe_cnt !== '0 || ov_cnt !== '0) begin
      errors++;
      $display("FAIL midrst_cnt fe=%0d ov=%0d want 0",
               fe_cnt, ov_cnt);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (dut.state_q !== IDLE) begin
      errors++;
      $display("FAIL midrst_state st=%0d want IDLE", dut.state_q);
    end
    rxd.rxd_ready = 1'b1;
    send_byte(8'h7E, 1'b1, 1);
    repeat (20) @(negedge clk);
    checks++;
    if (got_q.size() != 1 || got_q[0] !== 8'h7E) begin
      errors++;
      $display("FAIL midrst_byte n=%0d want 1 byte 7E",
               got_q.size());
    end
  endtask

  task automatic test_full_pop();
    int n0;
    rxd.rxd_ready = 1'b0;
    n0 = acc_q.size();
    for (int i = 0; i < DEPTH; i++) begin
      send_byte(8'($urandom), 1'b1, 1);
    end
    checks++;
    if (fifo_level !== LW'(DEPTH)) begin
      errors++;
      $display("FAIL fullpop_fill lvl=%0d want %0d",
               fifo_level, DEPTH);
    end
    @(negedge clk);
    fork
      send_byte(8'($urandom), 1'b1, 1);
      begin
        repeat (154) @(posedge clk);
        @(negedge clk);
        rxd.rxd_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rxd.rxd_ready = 1'b0;
      end
    join
    repeat (5) @(negedge clk);
    checks++;
    if (ov_seen != exp_ovf || exp_ovf != 1) begin
      errors++;
      $display("FAIL fullpop_ovf pulses=%0d model=%0d want 1",
               ov_seen, exp_ovf);
    end
    checks++;
    if (fifo_level !== LW'(acc_q.size() - got_q.size())) begin
      errors++;
      $display("FAIL fullpop_level got=%0d want %0d", fifo_level,
               acc_q.size() - got_q.size());
    end
    rxd.rxd_ready = 1'b1;
    repeat (12) @(negedge clk);
    checks++;
    if (got_q.size() != acc_q.size() ||
        acc_q.size() != n0 + DEPTH) begin
      errors++;
      $display("FAIL fullpop_len got=%0d want %0d",
               got_q.size(), n0 + DEPTH);
    end else begin
      for (int i = 0; i < got_q.size(); i++) begin
        checks++;
        if (got_q[i] !== acc_q[i]) begin
          errors++;
          $display("FAIL fullpop_data[%0d] got=%h want %h",
                   i, got_q[i], acc_q[i]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    bit done;
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          send_byte(8'($urandom), 1'b1, 1);
        end
        done = 1'b1;
      end
      while (!done) begin
        rxd.rxd_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
      end
    join
    rxd.rxd_ready = 1'b1;
    repeat (12) @(negedge clk);
    checks++;
    if (got_q.size() != acc_q.size() || fe_seen != 0 ||
        ov_seen != exp_ovf) begin
      errors++;
      $display("FAIL b2b_len got=%0d want %0d fe=%0d ov=%0d",
               got_q.size(), acc_q.size(), fe_seen, ov_seen);
    end else begin
      for (int i = 0; i < got_q.size(); i++) begin
        checks++;
        if (got_q[i] !== acc_q[i]) begin
          errors++;
          $display("FAIL b2b_data[%0d] got=%h want %h",
                   i, got_q[i], acc_q[i]);
        end
      end
    end
  endtask

  initial begin
    rxd.rxd_ready = 1'b0;
    test_reset();
    test_single();
    test_glitch();
    test_frame_err();
    test_overflow();
    test_reset_midframe();
    test_full_pop();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
